// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and MEM-stage controller states.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memctl_state_t;

endpackage

// File: rtl/mem_stage_ctrl_link_reg.sv
// LL/SC link register: set by a completed LL, cleared by SC/own store or a
// matching coherence snoop. A clear always wins over a simultaneous set.
module link_reg
  import cpu_types_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         set,
  input  logic [W-1:0] set_addr,
  input  logic         clear,
  input  logic         snoop_inv,
  input  logic [W-1:0] snoop_addr,
  output logic         link_valid,
  output logic [W-1:0] link_addr
);

  logic snoop_hit;

  // Word-granular match; the snoop may also hit the address being linked this cycle.
  assign snoop_hit = snoop_inv &
                     ((((snoop_addr ^ link_addr) >> 2) == '0) |
                      (set & (((snoop_addr ^ set_addr) >> 2) == '0)));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (clear | snoop_hit) begin
      link_valid <= 1'b0;
    end else if (set) begin
      link_valid <= 1'b1;
      link_addr  <= set_addr;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: dcache request sequencing, pipeline stall, LL/SC link,
// sticky halt and sticky wait-timeout error.
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ex_valid,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              ll_in,
  input  logic              sc_in,
  input  logic              halt_in,
  input  logic [WORD_W-1:0] aluResult,
  input  logic [WORD_W-1:0] storeData,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] portOut,
  output logic [WORD_W-1:0] dataWriteVal,
  output logic              mem_stall,
  output logic              memwb_en,
  output logic              halt_out,
  output logic              timeout_err
);

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  memctl_state_t     state, next_state;
  logic              ren, wen, stall;
  logic              sc_fail, mem_op, done_hit;
  logic              link_set, link_clr, link_valid;
  logic [WORD_W-1:0] link_addr;
  logic [WORD_W-1:0] load_buf;
  logic [7:0]        wait_cnt;

  assign dmemaddr  = {aluResult[WORD_W-1:2], 2'b00};
  assign dmemstore = storeData;
  assign portOut   = aluResult;

  assign sc_fail  = sc_in & ~(link_valid & (link_addr == dmemaddr));
  assign mem_op   = ex_valid & (memRead_in | memWrite_in) & ~halt_out & ~sc_fail;
  assign done_hit = (state == ACCESS) & dhit;

  always_comb begin
    next_state = state;
    ren        = 1'b0;
    wen        = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          ren        = memRead_in;
          wen        = memWrite_in;
          stall      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        ren   = memRead_in;
        wen   = memWrite_in;
        stall = 1'b1;
        if (dhit) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Requests must drop the instant reset asserts, even with a live op presented.
  assign dmemREN   = ren & n_rst;
  assign dmemWEN   = wen & n_rst;
  assign mem_stall = stall & n_rst;
  assign memwb_en  = ~mem_stall;

  // A passing SC only reaches DONE, by which time its completion has cleared the link.
  always_comb begin
    dataWriteVal = '0;
    if (sc_in)
      dataWriteVal = {{(WORD_W-1){1'b0}}, (state == DONE) | ~sc_fail};
    else if (memRead_in)
      dataWriteVal = load_buf;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      load_buf    <= '0;
      wait_cnt    <= '0;
      halt_out    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ACCESS) begin
        if (dhit) begin
          load_buf <= dmemload;
          wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + 8'd1;
          if (wait_cnt == WAIT_MAX - 8'd1) timeout_err <= 1'b1;
        end
      end
      if (ex_valid & halt_in & (state == IDLE)) halt_out <= 1'b1;
    end
  end

  assign link_set = done_hit & memRead_in & ll_in;
  assign link_clr = (done_hit & sc_in) |
                    ((state == IDLE) & ex_valid & sc_in & sc_fail & ~halt_out) |
                    (done_hit & memWrite_in & ~sc_in & link_valid & (dmemaddr == link_addr));

  link_reg #(.W(WORD_W)) u_link (
    .clk        (clk),
    .n_rst      (n_rst),
    .set        (link_set),
    .set_addr   (dmemaddr),
    .clear      (link_clr),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .link_valid (link_valid),
    .link_addr  (link_addr)
  );

endmodule
